// File: rtl/sram_like_responder_if.sv
// Purpose: sram-like request/response bus between a master (IF/MEM stage) and a responder.
// Latency: n/a (wires only); addr_ok is combinational in the responder, data_ok/rdata registered.
// Backpressure: master holds request fields until addr_ok; responses cannot be backpressured.
interface sram_like_responder_if;
    logic        req;      // request valid
    logic        wr;       // 1 = write, 0 = read
    logic [1:0]  size;     // 0 byte, 1 half, 2 word (informational)
    logic [3:0]  wstrb;    // byte write enables
    logic [31:0] addr;     // byte address
    logic [31:0] wdata;    // write data
    logic        addr_ok;  // request accepted this cycle
    logic        data_ok;  // response valid this cycle
    logic [31:0] rdata;    // read data (0 for write responses)

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_responder.sv
// Purpose: sram-like bus responder; queues accepted requests in order and issues each to a 1-cycle sync RAM port.
// Latency: accept is combinational; data_ok arrives RESP_DELAY cycles after accept (never earlier than 2).
// Backpressure: addr_ok drops when the queue holds DEPTH entries or hold_req_i=1; hold_resp_i stalls the head.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       req/wr/size/wstrb/addr/wdata in, addr_ok/data_ok/rdata out
//   hold_req_i        force addr_ok low (busy emulation)
//   hold_resp_i       suppress data_ok; head entry waits
//   ram_*_o           RAM request, valid in the handshake cycle only (ram_en_o / ram_wen_o)
//   ram_rdata_i       RAM read data, valid the cycle after ram_en_o
module sram_like_responder #(
    parameter int DEPTH      = 4,
    parameter int MEM_AW     = 16,
    parameter int RESP_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_like_responder_if.slave  bus,
    input  logic                  hold_req_i,
    input  logic                  hold_resp_i,
    output logic                  ram_en_o,
    output logic [3:0]            ram_wen_o,
    output logic [MEM_AW-1:0]     ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Queue state, one slot per outstanding request.
    logic [DEPTH-1:0] vld_q;           // slot holds an unanswered request
    logic [DEPTH-1:0] cap_q;           // slot's response data has been captured
    logic [31:0]      data_q [DEPTH];  // captured response data
    logic [DW-1:0]    cnt_q  [DEPTH];  // remaining delay, saturates at 0

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // The RAM answers one cycle after the handshake; remember which slot it belongs to.
    logic             pend_vld_q;
    logic [PW-1:0]    pend_idx_q;
    logic             pend_wr_q;

    logic             data_ok_q;
    logic [31:0]      rdata_q;

    logic             acc;
    logic [PW-1:0]    cand;
    logic             pend_hit;
    logic [31:0]      cap_val;
    logic             fire;
    logic             unused_ok;

    // Accept: no pop-through, the count only drops after data_ok has been seen.
    assign acc = ~reset & bus.req & ~hold_req_i & (count_q < CW'(DEPTH));

    assign bus.addr_ok = acc;
    assign bus.data_ok = data_ok_q;
    assign bus.rdata   = rdata_q;

    assign ram_en_o    = acc;
    assign ram_wen_o   = (acc & bus.wr) ? bus.wstrb : 4'b0000;
    assign ram_addr_o  = bus.addr[MEM_AW+1:2];
    assign ram_wdata_o = bus.wdata;

    // While data_ok is out, the head is still in the queue (it pops at the end of that
    // cycle), so the next response candidate is the entry behind it. This is what lets
    // back-to-back requests produce back-to-back responses.
    assign cand     = data_ok_q ? next_ptr(rd_ptr_q) : rd_ptr_q;
    assign pend_hit = pend_vld_q & (pend_idx_q == cand);
    assign cap_val  = pend_wr_q ? 32'h0 : ram_rdata_i;

    // cnt <= 1 means the counter reaches 0 at this edge, so data_ok lands exactly
    // RESP_DELAY cycles after accept. Data being captured this very cycle is forwarded.
    assign fire = vld_q[cand]
                & ~(data_ok_q & (cand == rd_ptr_q))
                & (cap_q[cand] | pend_hit)
                & (cnt_q[cand] <= DW'(1))
                & ~hold_resp_i;

    // Size and the aliased/sub-word address bits carry no meaning for this responder.
    assign unused_ok = ^{bus.size, bus.addr};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            vld_q      <= '0;
            cap_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            pend_wr_q  <= 1'b0;
            data_ok_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end

            // Capture is unconditional so a later RAM read cannot overwrite this slot's data.
            if (pend_vld_q) begin
                data_q[pend_idx_q] <= cap_val;
                cap_q[pend_idx_q]  <= 1'b1;
            end

            if (data_ok_q) begin
                vld_q[rd_ptr_q] <= 1'b0;
                cap_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= next_ptr(rd_ptr_q);
            end

            if (acc) begin
                vld_q[wr_ptr_q] <= 1'b1;
                cap_q[wr_ptr_q] <= 1'b0;
                cnt_q[wr_ptr_q] <= DW'(RESP_DELAY - 1);
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end

            pend_vld_q <= acc;
            pend_idx_q <= wr_ptr_q;
            pend_wr_q  <= bus.wr;

            count_q   <= count_q + CW'(acc) - CW'(data_ok_q);
            data_ok_q <= fire;
            if (fire) begin
                rdata_q <= cap_q[cand] ? data_q[cand] : cap_val;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Purpose: self-checking bench for sram_like_responder with a behavioural 1-cycle sync RAM.
// Latency: checks exact accept and data_ok cycles against RESP_DELAY=2.
// Backpressure: exercises hold_req, hold_resp, full queue and mid-operation reset.
module tb_sram_like_responder;

    logic        clk;
    logic        reset;
    logic        hold_req;
    logic        hold_resp;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    sram_like_responder_if bus();

    sram_like_responder #(
        .DEPTH      (4),
        .MEM_AW     (16),
        .RESP_DELAY (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .hold_req_i  (hold_req),
        .hold_resp_i (hold_resp),
        .ram_en_o    (ram_en),
        .ram_wen_o   (ram_wen),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM seen by the DUT.
    logic [31:0] ram [0:65535];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= ram[ram_addr];
        end
    end

    // Independent reference memory, updated from the bench's own request fields.
    logic [31:0] ref_mem [0:65535];
    logic [31:0] exp_q [$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard: push expected response at each handshake, pop at each data_ok.
    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.data_ok) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_data_ok @cyc %0d: got rdata %h want no response", cyc, bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_rdata", bus.rdata, e);
                end
            end
            if (bus.req && bus.addr_ok) begin
                if (bus.wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.wstrb[b]) ref_mem[bus.addr[17:2]][8*b +: 8] = bus.wdata[8*b +: 8];
                    end
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(ref_mem[bus.addr[17:2]]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic drv(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = s;
        bus.size  = 2'd2;
    endtask

    task automatic idle();
        bus.req   = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
        bus.wstrb = 4'h0;
        bus.size  = 2'd0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step();
            n++;
        end
        chk(nm, exp_q.size(), 0);
        step();
    endtask

    task automatic preload(input int idx, input logic [31:0] v);
        ram[idx]     = v;
        ref_mem[idx] = v;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [15:0] exp_raddr;
        logic [3:0]  exp_wen;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         4'b0000, 16'h0010, 4'b0000, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h0000_0080, 32'hAABB_CCDD, 4'b0011, 16'h0020, 4'b0011, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0080, 32'h0,         4'b0000, 16'h0020, 4'b0000, 32'h1122_CCDD};
        vecs[3] = '{1'b0, 32'hFFFC_0082, 32'h0,         4'b0000, 16'h0020, 4'b0000, 32'h1122_CCDD};
        vecs[4] = '{1'b1, 32'h0000_00C3, 32'h1234_5678, 4'b1000, 16'h0030, 4'b1000, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_00C0, 32'h0,         4'b0000, 16'h0030, 4'b0000, 32'h12FE_F00D};
        vecs[6] = '{1'b1, 32'h0000_00C0, 32'hFFFF_FFFF, 4'b0000, 16'h0030, 4'b0000, 32'h0};
        vecs[7] = '{1'b0, 32'h0000_00C1, 32'h5555_5555, 4'b1111, 16'h0030, 4'b0000, 32'h12FE_F00D};

        for (int i = 0; i < 65536; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        preload(16'h0010, 32'hDEAD_BEEF);
        preload(16'h0020, 32'h1122_3344);
        preload(16'h0030, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) preload(16'h0100 + i, 32'hA000_0000 + i);
        preload(16'h0200, 32'h0A0A_0A0A);
        preload(16'h0201, 32'h0B0B_0B0B);
        ram_rdata = 32'h0;

        idle();
        hold_req  = 1'b0;
        hold_resp = 1'b0;
        reset     = 1'b1;

        // Reset: request present but nothing may be accepted.
        step();
        drv(1'b0, 32'h40, 32'h0, 4'h0);
        smp();
        chk("rst_addr_ok", bus.addr_ok, 0);
        chk("rst_ram_en", ram_en, 0);
        step();
        idle();
        reset = 1'b0;
        smp();
        chk("rst_data_ok", bus.data_ok, 0);
        chk("rst_rdata", bus.rdata, 0);

        // Table: isolated transactions, exact handshake and response timing.
        for (int v = 0; v < 8; v++) begin
            step();
            drv(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            smp();
            chk("vec_addr_ok", bus.addr_ok, 1);
            chk("vec_ram_en", ram_en, 1);
            chk("vec_ram_addr", ram_addr, vecs[v].exp_raddr);
            chk("vec_ram_wen", ram_wen, vecs[v].exp_wen);
            chk("vec_ram_wdata", ram_wdata, vecs[v].wdata);
            step();
            idle();
            smp();
            chk("vec_no_early_data_ok", bus.data_ok, 0);
            chk("vec_idle_ram_en", ram_en, 0);
            step();
            smp();
            chk("vec_data_ok", bus.data_ok, 1);
            chk("vec_rdata", bus.rdata, vecs[v].exp_rdata);
            step();
            smp();
            chk("vec_data_ok_single", bus.data_ok, 0);
            chk("vec_rdata_hold", bus.rdata, vecs[v].exp_rdata);
        end
        drain("vec_drain");

        // Full queue under hold_resp: 4 accepted, 5th refused until a pop completes.
        hold_resp = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            drv(1'b0, 32'h400 + 4 * i, 32'h0, 4'h0);
            smp();
            chk("full_accept", bus.addr_ok, (i < 4) ? 1 : 0);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            smp();
            chk("full_blocked", bus.addr_ok, 0);
            chk("full_held_resp", bus.data_ok, 0);
        end
        step();
        hold_resp = 1'b0;
        smp();
        chk("full_release_addr_ok", bus.addr_ok, 0);
        chk("full_release_data_ok", bus.data_ok, 0);
        step();
        smp();
        chk("full_pop_data_ok", bus.data_ok, 1);
        chk("full_pop_no_pass", bus.addr_ok, 0);
        step();
        smp();
        chk("full_5th_accept", bus.addr_ok, 1);
        chk("full_b2b_1", bus.data_ok, 1);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("full_b2b_n", bus.data_ok, 1);
            step();
        end
        smp();
        chk("full_done", bus.data_ok, 0);
        drain("full_drain");

        // hold_req blocks acceptance and RAM access.
        hold_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 0) drv(1'b0, 32'h40, 32'h0, 4'h0);
            smp();
            chk("hreq_addr_ok", bus.addr_ok, 0);
            chk("hreq_ram_en", ram_en, 0);
        end
        step();
        hold_req = 1'b0;
        smp();
        chk("hreq_release_addr_ok", bus.addr_ok, 1);
        chk("hreq_release_ram_en", ram_en, 1);
        step();
        idle();
        drain("hreq_drain");

        // Reset with 3 outstanding reads: no stale responses afterwards.
        hold_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            drv(1'b0, 32'h400 + 4 * i, 32'h0, 4'h0);
            smp();
            chk("mrst_accept", bus.addr_ok, 1);
        end
        step();
        idle();
        reset     = 1'b1;
        hold_resp = 1'b0;
        smp();
        chk("mrst_in_reset", bus.data_ok, 0);
        step();
        reset = 1'b0;
        smp();
        chk("mrst_rdata_clr", bus.rdata, 0);
        for (int k = 0; k < 6; k++) begin
            chk("mrst_no_stale", bus.data_ok, 0);
            step();
            smp();
        end
        step();
        drv(1'b0, 32'h40, 32'h0, 4'h0);
        smp();
        chk("mrst_new_accept", bus.addr_ok, 1);
        step();
        idle();
        smp();
        chk("mrst_new_early", bus.data_ok, 0);
        step();
        smp();
        chk("mrst_new_data_ok", bus.data_ok, 1);
        chk("mrst_new_rdata", bus.rdata, 32'hDEAD_BEEF);
        drain("mrst_drain");

        // A then B back-to-back with hold_resp: A's capture must not be lost to B.
        step();
        hold_resp = 1'b1;
        drv(1'b0, 32'h800, 32'h0, 4'h0);
        smp();
        chk("ab_accept_a", bus.addr_ok, 1);
        step();
        drv(1'b0, 32'h804, 32'h0, 4'h0);
        smp();
        chk("ab_accept_b", bus.addr_ok, 1);
        step();
        idle();
        smp();
        chk("ab_hold_1", bus.data_ok, 0);
        step();
        smp();
        chk("ab_hold_2", bus.data_ok, 0);
        step();
        hold_resp = 1'b0;
        smp();
        chk("ab_release", bus.data_ok, 0);
        step();
        smp();
        chk("ab_a_data_ok", bus.data_ok, 1);
        chk("ab_a_rdata", bus.rdata, 32'h0A0A_0A0A);
        step();
        smp();
        chk("ab_b_data_ok", bus.data_ok, 1);
        chk("ab_b_rdata", bus.rdata, 32'h0B0B_0B0B);
        step();
        smp();
        chk("ab_done", bus.data_ok, 0);
        drain("ab_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
